// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg : shared encodings for the multicycle control unit and the ALU
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package control_pkg;

  typedef enum logic [2:0] {
    ALU_SUM         = 3'd0,
    ALU_SHIFT_LEFT  = 3'd1,
    ALU_SUB         = 3'd2,
    ALU_LOAD        = 3'd3,
    ALU_XOR         = 3'd4,
    ALU_SHIFT_RIGHT = 3'd5,
    ALU_NOT         = 3'd6,
    ALU_AND         = 3'd7
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_LUI       = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_HALT      = 4'd11,
    S_FAULT     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_U = 2'd3
  } imm_sel_t;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'd0,
    SRC_B_FOUR = 2'd1,
    SRC_B_IMM  = 2'd2
  } src_b_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode : {funct7[5], funct3, is_imm} -> ALU op plus illegal flag
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_op_decode
  import control_pkg::*;
(
  input  logic       funct7_5,
  input  logic [2:0] funct3,
  input  logic       is_imm,
  output alu_op_t    op,
  output logic       illegal
);

  always_comb begin
    op      = ALU_SUM;
    illegal = 1'b0;
    case (funct3)
      3'b000: op = (funct7_5 && !is_imm) ? ALU_SUB : ALU_SUM;
      3'b001: begin
        op      = ALU_SHIFT_LEFT;
        illegal = funct7_5 && !is_imm;
      end
      3'b100: op = ALU_XOR;
      // Arithmetic right shift is not supported by the ALU.
      3'b101: begin
        op      = ALU_SHIFT_RIGHT;
        illegal = funct7_5;
      end
      3'b111: op = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit : multicycle control FSM driving the 64-bit ALU datapath
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_control_unit
  import control_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned IMEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        equal,
  input  logic        less,
  output logic [2:0]  alu_funct,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        ab_load,
  output logic        alu_out_load,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        pc_src,
  output logic        wb_sel,
  output logic        halted,
  output logic        fault
);

  localparam logic [7:0] WAIT_LIMIT = 8'(IMEM_WAIT_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  alu_op_t    op;
  alu_op_t    dec_op;
  logic       dec_illegal;
  src_b_t     src_b;
  imm_sel_t   imm;
  logic [6:0] strb;
  logic       in_wait;
  logic       timeout;
  logic       taken;
  logic       br_illegal;

  wire [6:0] opcode = instr[6:0];
  wire [2:0] funct3 = instr[14:12];
  wire [6:0] funct7 = instr[31:25];

  // Register-index fields and the width parameter carry no control meaning.
  logic unused_ok;
  assign unused_ok = ^{XLEN[0], instr[24:15], instr[11:7]};

  alu_op_decode u_alu_op_decode (
    .funct7_5 (instr[30]),
    .funct3   (funct3),
    .is_imm   (state == S_EXEC_I),
    .op       (dec_op),
    .illegal  (dec_illegal)
  );

  assign in_wait = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign timeout = in_wait && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    taken      = 1'b0;
    br_illegal = 1'b0;
    case (funct3)
      3'b000:  taken = equal;
      3'b001:  taken = !equal;
      3'b100:  taken = less;
      3'b101:  taken = !less;
      default: br_illegal = 1'b1;
    endcase
  end

  // strb = {ir_write, pc_write, ab_load, alu_out_load, mem_read, mem_write, reg_write}
  always_comb begin
    state_nxt = state;
    op        = ALU_SUM;
    alu_src_a = 1'b0;
    src_b     = SRC_B_REG;
    imm       = IMM_I;
    strb      = 7'b0;
    pc_src    = 1'b0;
    wb_sel    = 1'b0;
    case (state)
      S_FETCH: begin
        strb[2] = 1'b1;
        src_b   = SRC_B_FOUR;
        if (mem_ready) begin
          strb[6]   = 1'b1;
          strb[5]   = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        strb[4] = 1'b1;
        strb[3] = 1'b1;
        src_b   = SRC_B_IMM;
        imm     = IMM_B;
        case (opcode)
          OP_R:               state_nxt = S_EXEC_R;
          OP_IMM:             state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:          state_nxt = S_BRANCH;
          OP_LUI:             state_nxt = S_LUI;
          OP_SYSTEM:          state_nxt = S_HALT;
          default:            state_nxt = S_FAULT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        op        = dec_op;
        alu_src_a = 1'b1;
        strb[3]   = 1'b1;
        if (state == S_EXEC_I) begin
          src_b = SRC_B_IMM;
          imm   = IMM_I;
        end
        // R-type only defines funct7 values 0x00 and 0x20.
        if (dec_illegal || ((state == S_EXEC_R) && ((funct7 & 7'b1011111) != 7'b0)))
          state_nxt = S_FAULT;
        else
          state_nxt = S_ALU_WB;
      end
      S_LUI: begin
        op        = ALU_LOAD;
        src_b     = SRC_B_IMM;
        imm       = IMM_U;
        strb[3]   = 1'b1;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        strb[0]   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        src_b     = SRC_B_IMM;
        imm       = (opcode == OP_STORE) ? IMM_S : IMM_I;
        strb[3]   = 1'b1;
        state_nxt = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        strb[2] = 1'b1;
        if (mem_ready)    state_nxt = S_MEM_WB;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_MEM_WB: begin
        strb[0]   = 1'b1;
        wb_sel    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_WRITE: begin
        strb[1] = 1'b1;
        if (mem_ready)    state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        op        = ALU_SUB;
        pc_src    = 1'b1;
        strb[5]   = taken && !br_illegal;
        state_nxt = br_illegal ? S_FAULT : S_FETCH;
      end
      default: state_nxt = state;
    endcase
  end

  assign alu_funct = op;
  assign alu_src_b = src_b;
  assign imm_sel   = imm;
  assign {ir_write, pc_write, ab_load, alu_out_load, mem_read, mem_write, reg_write} =
         reset ? 7'b0 : strb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || mem_ready)
        wait_cnt <= 8'd0;
      else if (in_wait)
        wait_cnt <= wait_cnt + 8'd1;
      if (state == S_HALT)
        halted <= 1'b1;
      if (state == S_FAULT)
        fault <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit : directed instruction sequences with hand-computed outputs
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_unit;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_MULV  = 32'h022081B3;
  localparam logic [31:0] I_XORI  = 32'h0050C193;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_LD    = 32'h0080B283;
  localparam logic [31:0] I_SD    = 32'h0020B023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_EBRK  = 32'h00100073;

  // Strobe vector order: {ir_write, pc_write, ab_load, alu_out_load, mem_read, mem_write, reg_write}
  localparam logic [6:0] ST_NONE   = 7'b0000000;
  localparam logic [6:0] ST_FETCH  = 7'b1100100;
  localparam logic [6:0] ST_FWAIT  = 7'b0000100;
  localparam logic [6:0] ST_DECODE = 7'b0011000;
  localparam logic [6:0] ST_EXEC   = 7'b0001000;
  localparam logic [6:0] ST_WB     = 7'b0000001;
  localparam logic [6:0] ST_MREAD  = 7'b0000100;
  localparam logic [6:0] ST_MWRITE = 7'b0000010;
  localparam logic [6:0] ST_PCW    = 7'b0100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        equal;
  logic        less;
  logic [2:0]  alu_funct;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  imm_sel;
  logic        ir_write, pc_write, ab_load, alu_out_load;
  logic        mem_read, mem_write, reg_write;
  logic        pc_src, wb_sel, halted, fault;
  logic [6:0]  strobes;

  int checks = 0;
  int errors = 0;

  assign strobes = {ir_write, pc_write, ab_load, alu_out_load, mem_read, mem_write, reg_write};

  always #5 clk = ~clk;

  mc_control_unit #(.XLEN(64), .IMEM_WAIT_MAX(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .equal        (equal),
    .less         (less),
    .alu_funct    (alu_funct),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .imm_sel      (imm_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .ab_load      (ab_load),
    .alu_out_load (alu_out_load),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .pc_src       (pc_src),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .fault        (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step(input logic rst, input logic [31:0] ir, input logic rdy,
                      input logic eq, input logic lt);
    @(negedge clk);
    reset     = rst;
    instr     = ir;
    mem_ready = rdy;
    equal     = eq;
    less      = lt;
    #1;
  endtask

  task automatic run(input logic [31:0] ir, input logic rdy);
    step(1'b0, ir, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; instr = 32'h0; mem_ready = 1'b0; equal = 1'b0; less = 1'b0;
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0);
    check("rst_strobes", 32'(strobes), 32'(ST_NONE));
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // add
    run(I_ADD, 1'b1);
    check("add_fetch", 32'(strobes), 32'(ST_FETCH));
    check("add_fetch_srcb", 32'(alu_src_b), 32'd1);
    run(I_ADD, 1'b1);
    check("add_decode", 32'(strobes), 32'(ST_DECODE));
    check("add_decode_imm", 32'(imm_sel), 32'd2);
    run(I_ADD, 1'b1);
    check("add_exec", 32'(strobes), 32'(ST_EXEC));
    check("add_funct", 32'(alu_funct), 32'd0);
    check("add_srca", 32'(alu_src_a), 32'd1);
    run(I_ADD, 1'b1);
    check("add_wb", 32'(strobes), 32'(ST_WB));
    check("add_wbsel", 32'(wb_sel), 32'd0);

    // sub
    run(I_SUB, 1'b1);
    check("sub_fetch", 32'(strobes), 32'(ST_FETCH));
    run(I_SUB, 1'b1);
    run(I_SUB, 1'b1);
    check("sub_funct", 32'(alu_funct), 32'd2);
    run(I_SUB, 1'b1);
    check("sub_wb", 32'(strobes), 32'(ST_WB));

    // illegal funct7 = 0x01
    run(I_MULV, 1'b1);
    run(I_MULV, 1'b1);
    run(I_MULV, 1'b1);
    run(I_MULV, 1'b1);
    check("mulv_no_wb", 32'(strobes), 32'(ST_NONE));
    run(I_MULV, 1'b1);
    check("mulv_fault", 32'(fault), 32'd1);
    check("mulv_strobes", 32'(strobes), 32'(ST_NONE));
    step(1'b1, I_LD, 1'b1, 1'b0, 1'b0);

    // ld with five wait cycles
    run(I_LD, 1'b1);
    check("rst_clears_fault", 32'(fault), 32'd0);
    check("ld_fetch", 32'(strobes), 32'(ST_FETCH));
    run(I_LD, 1'b1);
    run(I_LD, 1'b1);
    check("ld_addr", 32'(strobes), 32'(ST_EXEC));
    check("ld_addr_imm", 32'(imm_sel), 32'd0);
    check("ld_addr_srcb", 32'(alu_src_b), 32'd2);
    for (int i = 0; i < 5; i++) begin
      run(I_LD, 1'b0);
      check("ld_wait_read", 32'(strobes), 32'(ST_MREAD));
    end
    run(I_LD, 1'b1);
    check("ld_ready_read", 32'(strobes), 32'(ST_MREAD));
    run(I_LD, 1'b1);
    check("ld_memwb", 32'(strobes), 32'(ST_WB));
    check("ld_wbsel", 32'(wb_sel), 32'd1);

    // xori
    run(I_XORI, 1'b1);
    run(I_XORI, 1'b1);
    run(I_XORI, 1'b1);
    check("xori_funct", 32'(alu_funct), 32'd4);
    check("xori_srcb", 32'(alu_src_b), 32'd2);
    check("xori_imm", 32'(imm_sel), 32'd0);
    run(I_XORI, 1'b1);
    check("xori_wb", 32'(strobes), 32'(ST_WB));

    // lui
    run(I_LUI, 1'b1);
    run(I_LUI, 1'b1);
    run(I_LUI, 1'b1);
    check("lui_funct", 32'(alu_funct), 32'd3);
    check("lui_imm", 32'(imm_sel), 32'd3);
    check("lui_strobes", 32'(strobes), 32'(ST_EXEC));
    run(I_LUI, 1'b1);

    // branches
    run(I_BEQ, 1'b1);
    run(I_BEQ, 1'b1);
    step(1'b0, I_BEQ, 1'b1, 1'b1, 1'b0);
    check("beq_taken", 32'(strobes), 32'(ST_PCW));
    check("beq_pcsrc", 32'(pc_src), 32'd1);
    check("beq_funct", 32'(alu_funct), 32'd2);
    run(I_BNE, 1'b1);
    check("bne_fetch", 32'(strobes), 32'(ST_FETCH));
    run(I_BNE, 1'b1);
    step(1'b0, I_BNE, 1'b1, 1'b1, 1'b0);
    check("bne_not_taken", 32'(strobes), 32'(ST_NONE));
    check("bne_pcsrc", 32'(pc_src), 32'd1);
    run(I_BLT, 1'b1);
    run(I_BLT, 1'b1);
    step(1'b0, I_BLT, 1'b1, 1'b0, 1'b1);
    check("blt_taken", 32'(strobes), 32'(ST_PCW));

    // mem_ready exactly at the wait limit counts as success
    for (int i = 0; i < 255; i++) run(I_ADD, 1'b0);
    run(I_ADD, 1'b1);
    check("limit_ready_fetch", 32'(strobes), 32'(ST_FETCH));
    run(I_ADD, 1'b1);
    check("limit_ready_decode", 32'(strobes), 32'(ST_DECODE));
    run(I_ADD, 1'b1);
    run(I_ADD, 1'b1);

    // fetch timeout
    for (int i = 0; i < 256; i++) run(I_ADD, 1'b0);
    check("timeout_last_fetch", 32'(strobes), 32'(ST_FWAIT));
    check("timeout_no_fault_yet", 32'(fault), 32'd0);
    run(I_ADD, 1'b0);
    check("timeout_fault_state", 32'(strobes), 32'(ST_NONE));
    run(I_ADD, 1'b0);
    check("timeout_fault", 32'(fault), 32'd1);
    step(1'b1, I_EBRK, 1'b1, 1'b0, 1'b0);

    // ebreak
    run(I_EBRK, 1'b1);
    check("timeout_rst_fault", 32'(fault), 32'd0);
    check("ebrk_fetch", 32'(strobes), 32'(ST_FETCH));
    run(I_EBRK, 1'b1);
    run(I_EBRK, 1'b1);
    check("ebrk_halt_strobes", 32'(strobes), 32'(ST_NONE));
    for (int i = 0; i < 8; i++) begin
      run(I_EBRK, 1'b1);
      check("ebrk_halted", 32'(halted), 32'd1);
      check("ebrk_quiet", 32'(strobes), 32'(ST_NONE));
    end
    step(1'b1, I_SD, 1'b1, 1'b0, 1'b0);

    // sd with reset during the write wait
    run(I_SD, 1'b1);
    check("sd_rst_halted", 32'(halted), 32'd0);
    run(I_SD, 1'b1);
    run(I_SD, 1'b1);
    check("sd_addr_imm", 32'(imm_sel), 32'd1);
    run(I_SD, 1'b0);
    check("sd_write", 32'(strobes), 32'(ST_MWRITE));
    run(I_SD, 1'b0);
    check("sd_write_hold", 32'(strobes), 32'(ST_MWRITE));
    step(1'b1, I_SD, 1'b0, 1'b0, 1'b0);
    run(I_SD, 1'b0);
    check("sd_rst_fetch", 32'(strobes), 32'(ST_FWAIT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
